quadrature_step_generator: RTL and testbench

- Transmit-side counterpart of the rotary shaft encoder decoder: converts handshaked step requests into two-phase quadrature waveforms on rot_a/rot_b.
- Optional contact-bounce glitches on every edge.
- Drives the decoder input pins in loopback benches and on-board self-test.
- Keeps a signed detent position count.

---
 rtl/quadrature_step_generator.sv | 138 +++++++++++++
 tb/tb_quadrature_step_generator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/quadrature_step_generator.sv
// Converts handshaked step requests into two-phase quadrature on rot_a/rot_b,
// with optional contact-bounce glitches and a signed detent position count.
module quadrature_step_generator #(
    parameter int PHASE_CYCLES  = 4,
    parameter int BOUNCE_PULSES = 0,
    parameter int POS_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_valid,
    input  logic                 step_dir,
    output logic                 step_ready,
    output logic                 rot_a,
    output logic                 rot_b,
    output logic                 busy,
    output logic                 step_done,
    output logic [POS_WIDTH-1:0] position
);

    localparam int BNC    = 2 * BOUNCE_PULSES;
    localparam int PH_LEN = BNC + PHASE_CYCLES;
    localparam int CNT_W  = $clog2(PH_LEN + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PH1  = 3'd1;
    localparam logic [2:0] S_PH2  = 3'd2;
    localparam logic [2:0] S_PH3  = 3'd3;
    localparam logic [2:0] S_PH4  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic                 rot_a_q, rot_a_d;
    logic                 rot_b_q, rot_b_d;
    logic                 done_q, done_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    logic       phase_end;
    logic       glitch;
    logic       bad;
    logic [2:0] out_ph;
    logic       lead, lag;

    // cnt_q is the bounce/hold index j of the value registered at this edge;
    // it reaches PH_LEN one edge after the last hold cycle of the phase.
    if (BNC > 0) begin : g_bounce
        assign glitch = cnt_q[0] && (cnt_q < CNT_W'(BNC));
    end else begin : g_clean
        assign glitch = 1'b0;
    end

    assign phase_end = (cnt_q == CNT_W'(PH_LEN));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_a_d = rot_a_q;
        rot_b_d = rot_b_q;
        done_d  = 1'b0;
        pos_d   = pos_q;
        out_ph  = state_q;
        bad     = 1'b0;
        lead    = 1'b0;
        lag     = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (step_valid) begin
                    state_d = S_PH1;
                    cnt_d   = '0;
                    dir_d   = step_dir;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PH1, S_PH2, S_PH3, S_PH4: begin
                if (phase_end) begin
                    cnt_d = CNT_W'(1);
                    if (state_q == S_PH4) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pos_d   = dir_q ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
                    end else begin
                        state_d = state_q + 3'd1;
                    end
                    out_ph = state_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    bad   = glitch;
                end
                // Odd bounce cycles show the changing line at its old level.
                unique case (out_ph)
                    S_PH1:   begin lead = ~bad; lag = 1'b0; end
                    S_PH2:   begin lead = 1'b1; lag = ~bad; end
                    S_PH3:   begin lead = bad;  lag = 1'b1; end
                    S_PH4:   begin lead = 1'b0; lag = bad;  end
                    default: begin lead = 1'b0; lag = 1'b0; end
                endcase
                rot_a_d = dir_q ? lead : lag;
                rot_b_d = dir_q ? lag  : lead;
            end
            default: begin
                state_d = S_IDLE;
                rot_a_d = 1'b0;
                rot_b_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_a_q <= 1'b0;
            rot_b_q <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_a_q <= rot_a_d;
            rot_b_q <= rot_b_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
        end
    end

    assign step_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy       = ~step_ready;
    assign rot_a      = rot_a_q;
    assign rot_b      = rot_b_q;
    assign step_done  = done_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Directed bench: clean-edge instance (dut0) and bounce instance (dut1, BOUNCE_PULSES=2).
module tb_quadrature_step_generator;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n, v0, v1, d0, d1;
    logic       rdy0, a0, b0, busy0, done0;
    logic       rdy1, a1, b1, busy1, done1;
    logic [7:0] pos0, pos1;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] cap_a, cap_b, cap_d, cap_r;
    logic [7:0]  cap_pos;

    always #5 clk = ~clk;

    quadrature_step_generator #(.PHASE_CYCLES(4), .BOUNCE_PULSES(0), .POS_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst0_n), .step_valid(v0), .step_dir(d0), .step_ready(rdy0),
        .rot_a(a0), .rot_b(b0), .busy(busy0), .step_done(done0), .position(pos0)
    );

    quadrature_step_generator #(.PHASE_CYCLES(4), .BOUNCE_PULSES(2), .POS_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .step_valid(v1), .step_dir(d1), .step_ready(rdy1),
        .rot_a(a1), .rot_b(b1), .busy(busy1), .step_done(done1), .position(pos1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; cap_*[t] holds the value after edge k+t,
    // k being the acceptance edge. With pulse set, step_valid blips while busy.
    task automatic step(input int which, input logic dir, input int n, input logic pulse);
        if (which == 0) begin v0 = 1'b1; d0 = dir; end
        else            begin v1 = 1'b1; d1 = dir; end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        cap_a = '0; cap_b = '0; cap_d = '0; cap_r = '0; cap_pos = 8'hxx;
        for (int t = 1; t <= n; t++) begin
            @(posedge clk); #1;
            cap_a[t] = (which == 0) ? a0    : a1;
            cap_b[t] = (which == 0) ? b0    : b1;
            cap_d[t] = (which == 0) ? done0 : done1;
            cap_r[t] = (which == 0) ? rdy0  : rdy1;
            if ((which == 0) ? done0 : done1) cap_pos = (which == 0) ? pos0 : pos1;
            if (pulse && which == 0) v0 = (t == 3) || (t == 10);
        end
        v0 = 1'b0;
    endtask

    task automatic reset0();
        rst0_n = 1'b0;
        @(posedge clk); #1;
        rst0_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        int   ndone, last, bad;
        rst0_n = 1'b0; rst1_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = 1'b0; d1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", a0, 0);
        chk("rst_b", b0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pos", pos0, 0);
        rst0_n = 1'b1; rst1_n = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen = seen | done0 | a0 | b0 | ~rdy0;
        end
        chk("idle_quiet", seen, 0);

        // Abort during PH2 (t=6 -> A=1,B=1)
        v0 = 1'b1; d0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_pre_a", a0, 1);
        chk("abort_pre_b", b0, 1);
        #2 rst0_n = 1'b0;
        #1;
        chk("abort_a", a0, 0);
        chk("abort_b", b0, 0);
        chk("abort_pos", pos0, 0);
        chk("abort_ready", rdy0, 1);
        @(posedge clk); #1;
        rst0_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen = seen | done0 | a0 | b0 | ~rdy0;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_pos_after", pos0, 0);

        // CW clean, with ignored valid blips while busy
        step(0, 1'b1, 20, 1'b1);
        chk("cw_a", cap_a, 64'h1FE);
        chk("cw_b", cap_b, 64'h1FE0);
        chk("cw_done", cap_d, 64'h20000);
        chk("cw_ready", cap_r, 64'h1E0000);
        chk("cw_pos", cap_pos, 8'h01);

        reset0();
        step(0, 1'b0, 20, 1'b0);
        chk("ccw_a", cap_a, 64'h1FE0);
        chk("ccw_b", cap_b, 64'h1FE);
        chk("ccw_done", cap_d, 64'h20000);
        chk("ccw_pos", cap_pos, 8'hFF);

        step(1, 1'b1, 36, 1'b0);
        chk("bnc_a", cap_a, 64'h15FFEA);
        chk("bnc_b", cap_b, 64'h15FFEA00);
        chk("bnc_done", cap_d, 64'h2_0000_0000);
        chk("bnc_pos", cap_pos, 8'h01);

        // Back-to-back: valid held high, 130 CW steps from 0
        reset0();
        v0 = 1'b1; d0 = 1'b1;
        ndone = 0; last = 0; bad = 0;
        for (int cyc = 0; cyc < 3000 && ndone < 130; cyc++) begin
            @(posedge clk); #1;
            if (done0) begin
                if (ndone > 0 && (cyc - last) != 18) bad++;
                last = cyc;
                ndone++;
                if (ndone == 130) v0 = 1'b0;
            end
        end
        v0 = 1'b0;
        chk("b2b_steps", ndone, 130);
        chk("b2b_gap_bad", bad, 0);
        chk("b2b_pos", pos0, 8'h82);

        step(0, 1'b0, 20, 1'b0);
        chk("wrap_dn1", cap_pos, 8'h81);
        step(0, 1'b0, 20, 1'b0);
        step(0, 1'b0, 20, 1'b0);
        chk("wrap_dn3", cap_pos, 8'h7F);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
